// File: rtl/digit_entry_ctrl.sv
// digit_entry_ctrl: front end for the 4-bit load register stage.
// Synchronizes and debounces an active-low push button. Each accepted press
// captures the switch bank into `digit` and raises `load` for one cycle. It
// also tracks the digits of a multi-digit entry, flags completion, and drops
// a partial entry after an idle timeout.
// dbg_state encoding: 0 IDLE, 1 WAIT_PRESS, 2 PRESS_DB, 3 LOAD, 4 REL_DB, 5 DONE.
module digit_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DIGITS          = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       btn,
  input  logic [3:0] sw,
  output logic       load,
  output logic [3:0] digit,
  output logic [1:0] digit_idx,
  output logic       done,
  output logic       timeout,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_PRESS = 3'd1,
    S_PRESS_DB   = 3'd2,
    S_LOAD       = 3'd3,
    S_REL_DB     = 3'd4,
    S_DONE       = 3'd5
  } state_e;

  // Press: the sample that leaves WAIT_PRESS counts as the first stable one,
  // so PRESS_DB accepts when the incremented count reaches DEBOUNCE_CYCLES-1.
  localparam logic [7:0]  DB_PRESS_LAST = 8'(DEBOUNCE_CYCLES - 1);
  // Release: the first high sample in REL_DB arms the count, then
  // DEBOUNCE_CYCLES further high samples are required.
  localparam logic [7:0]  DB_REL_LAST   = 8'(DEBOUNCE_CYCLES);
  localparam logic [15:0] TMO_LAST      = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  DIGITS_C      = 3'(DIGITS);

  state_e      state_q, state_d;
  logic        btn_meta_q, btn_s_q;
  logic [7:0]  db_q, db_d;
  logic [15:0] tmo_q, tmo_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  digit_q, digit_d;
  logic        load_q, done_q, timeout_q, timeout_d;

  // Two-flop synchronizer for the asynchronous button; idles released (1).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_meta_q <= 1'b1;
      btn_s_q    <= 1'b1;
    end else begin
      btn_meta_q <= btn;
      btn_s_q    <= btn_meta_q;
    end
  end

  // Next-state, counters and captured data; enable low overrides everything.
  always_comb begin
    state_d   = state_q;
    db_d      = db_q;
    tmo_d     = '0;
    idx_d     = idx_q;
    digit_d   = digit_q;
    timeout_d = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      idx_d   = '0;
      db_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          idx_d   = '0;
          db_d    = '0;
          state_d = S_WAIT_PRESS;
        end
        S_WAIT_PRESS: begin
          if (!btn_s_q) begin
            state_d = S_PRESS_DB;
            db_d    = '0;
          end else if (idx_q != 3'd0) begin
            // Idle time only matters once part of an entry exists.
            if (tmo_q == TMO_LAST) begin
              timeout_d = 1'b1;
              idx_d     = '0;
            end else begin
              tmo_d = tmo_q + 16'd1;
            end
          end
        end
        S_PRESS_DB: begin
          if (btn_s_q) begin
            state_d = S_WAIT_PRESS;
            db_d    = '0;
          end else if (db_q + 8'd1 == DB_PRESS_LAST) begin
            state_d = S_LOAD;
            digit_d = sw;
            db_d    = '0;
          end else begin
            db_d = db_q + 8'd1;
          end
        end
        S_LOAD: begin
          idx_d   = idx_q + 3'd1;
          db_d    = '0;
          state_d = S_REL_DB;
        end
        S_REL_DB: begin
          if (!btn_s_q) begin
            db_d = '0;
          end else if (db_q == DB_REL_LAST) begin
            db_d    = '0;
            state_d = (idx_q == DIGITS_C) ? S_DONE : S_WAIT_PRESS;
          end else begin
            db_d = db_q + 8'd1;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      db_q      <= '0;
      tmo_q     <= '0;
      idx_q     <= '0;
      digit_q   <= '0;
      load_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      db_q      <= db_d;
      tmo_q     <= tmo_d;
      idx_q     <= idx_d;
      digit_q   <= digit_d;
      load_q    <= (state_d == S_LOAD);
      done_q    <= (state_d == S_DONE);
      timeout_q <= timeout_d;
    end
  end

  assign load      = load_q;
  assign digit     = digit_q;
  assign digit_idx = idx_q[1:0];
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign dbg_state = state_q;

endmodule
